// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single external memory command port.
// Port 0 is instruction fetch, port 1 is load/store. Only one transaction
// is outstanding at a time, and conflicts are resolved round-robin. Every
// accepted request gets exactly one response pulse. A read that gets no
// reply within TIMEOUT cycles of command acceptance completes with err = 1.
module mem_port_arbiter #(
  parameter int AW      = 28,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk50mhz,
  input  logic            sys_rst_n,
  // requester 0 (instruction fetch)
  input  logic            m0_req_valid,
  output logic            m0_req_ready,
  input  logic            m0_req_we,
  input  logic [AW-1:0]   m0_req_addr,
  input  logic [DW-1:0]   m0_req_wdata,
  input  logic [DW/8-1:0] m0_req_wstrb,
  output logic            m0_rsp_valid,
  output logic [DW-1:0]   m0_rsp_rdata,
  output logic            m0_rsp_err,
  // requester 1 (load/store)
  input  logic            m1_req_valid,
  output logic            m1_req_ready,
  input  logic            m1_req_we,
  input  logic [AW-1:0]   m1_req_addr,
  input  logic [DW-1:0]   m1_req_wdata,
  input  logic [DW/8-1:0] m1_req_wstrb,
  output logic            m1_rsp_valid,
  output logic [DW-1:0]   m1_rsp_rdata,
  output logic            m1_rsp_err,
  // memory command / response side
  output logic            mem_cmd_valid,
  input  logic            mem_cmd_ready,
  output logic            mem_cmd_we,
  output logic [AW-1:0]   mem_cmd_addr,
  output logic [DW-1:0]   mem_cmd_wdata,
  output logic [DW/8-1:0] mem_cmd_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_rdata,
  output logic            busy
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]    state_r;
  logic          rr_r;        // owner of the last grant; the other side wins a conflict
  logic          owner_r;
  logic [CW-1:0] cnt_r;
  logic          cmd_valid_r;
  logic          cmd_we_r;
  logic [AW-1:0] cmd_addr_r;
  logic [DW-1:0] cmd_wdata_r;
  logic [SW-1:0] cmd_wstrb_r;
  logic          busy_r;
  logic [1:0]    rsp_valid_r;
  logic [DW-1:0] rsp0_rdata_r;
  logic [DW-1:0] rsp1_rdata_r;
  logic          rsp0_err_r;
  logic          rsp1_err_r;

  logic          grant_s;
  logic          hs_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic [SW-1:0] sel_wstrb_s;
  logic          deliver_s;
  logic [DW-1:0] dl_rdata_s;
  logic          dl_err_s;

  // Pick the requester to grant while idle and mux its request fields.
  always_comb begin
    grant_s = 1'b0;
    hs_s    = 1'b0;
    if (state_r == ST_IDLE) begin
      if (m0_req_valid && m1_req_valid) begin
        grant_s = ~rr_r;
        hs_s    = 1'b1;
      end else if (m0_req_valid) begin
        grant_s = 1'b0;
        hs_s    = 1'b1;
      end else if (m1_req_valid) begin
        grant_s = 1'b1;
        hs_s    = 1'b1;
      end else begin
        grant_s = 1'b0;
        hs_s    = 1'b0;
      end
    end else begin
      hs_s = 1'b0;
    end
    if (grant_s) begin
      sel_we_s    = m1_req_we;
      sel_addr_s  = m1_req_addr;
      sel_wdata_s = m1_req_wdata;
      sel_wstrb_s = m1_req_wstrb;
    end else begin
      sel_we_s    = m0_req_we;
      sel_addr_s  = m0_req_addr;
      sel_wdata_s = m0_req_wdata;
      sel_wstrb_s = m0_req_wstrb;
    end
  end

  assign m0_req_ready = hs_s & ~grant_s;
  assign m1_req_ready = hs_s & grant_s;

  // Decide whether this cycle completes the transaction, and with which payload.
  always_comb begin
    deliver_s  = 1'b0;
    dl_rdata_s = '0;
    dl_err_s   = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        if (mem_cmd_ready && cmd_we_r) begin
          deliver_s = 1'b1;
        end else begin
          deliver_s = 1'b0;
        end
      end
      ST_WAIT: begin
        // A reply in the last counted cycle beats the timeout.
        if (mem_rsp_valid) begin
          deliver_s  = 1'b1;
          dl_rdata_s = mem_rsp_rdata;
        end else if (cnt_r == CNT_LAST) begin
          deliver_s = 1'b1;
          dl_err_s  = 1'b1;
        end else begin
          deliver_s = 1'b0;
        end
      end
      default: begin
        deliver_s = 1'b0;
      end
    endcase
  end

  // Transaction sequencing: grant, command issue, read wait, response.
  always_ff @(posedge clk50mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      rr_r        <= 1'b1;
      owner_r     <= 1'b0;
      cnt_r       <= '0;
      cmd_valid_r <= 1'b0;
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= '0;
      cmd_wdata_r <= '0;
      cmd_wstrb_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            owner_r     <= grant_s;
            rr_r        <= grant_s;
            cmd_we_r    <= sel_we_s;
            cmd_addr_r  <= sel_addr_s;
            cmd_wdata_r <= sel_wdata_s;
            cmd_wstrb_r <= sel_wstrb_s;
            cmd_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (mem_cmd_ready) begin
            cmd_valid_r <= 1'b0;
            cnt_r       <= '0;
            state_r     <= cmd_we_r ? ST_RESP : ST_WAIT;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (deliver_s) begin
            state_r <= ST_RESP;
          end else begin
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          cmd_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Response registers: load the owner's outputs on completion, clear after the pulse.
  always_ff @(posedge clk50mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rsp_valid_r  <= 2'b00;
      rsp0_rdata_r <= '0;
      rsp1_rdata_r <= '0;
      rsp0_err_r   <= 1'b0;
      rsp1_err_r   <= 1'b0;
    end else if (deliver_s) begin
      if (owner_r) begin
        rsp_valid_r  <= 2'b10;
        rsp1_rdata_r <= dl_rdata_s;
        rsp1_err_r   <= dl_err_s;
      end else begin
        rsp_valid_r  <= 2'b01;
        rsp0_rdata_r <= dl_rdata_s;
        rsp0_err_r   <= dl_err_s;
      end
    end else begin
      rsp_valid_r  <= 2'b00;
      rsp0_rdata_r <= '0;
      rsp1_rdata_r <= '0;
      rsp0_err_r   <= 1'b0;
      rsp1_err_r   <= 1'b0;
    end
  end

  assign mem_cmd_valid = cmd_valid_r;
  assign mem_cmd_we    = cmd_we_r;
  assign mem_cmd_addr  = cmd_addr_r;
  assign mem_cmd_wdata = cmd_wdata_r;
  assign mem_cmd_wstrb = cmd_wstrb_r;
  assign busy          = busy_r;
  assign m0_rsp_valid  = rsp_valid_r[0];
  assign m0_rsp_rdata  = rsp0_rdata_r;
  assign m0_rsp_err    = rsp0_err_r;
  assign m1_rsp_valid  = rsp_valid_r[1];
  assign m1_rsp_rdata  = rsp1_rdata_r;
  assign m1_rsp_err    = rsp1_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-timing model (cycle arithmetic per request).
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk50mhz = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          m0_req_valid, m0_req_ready, m0_req_we;
  logic [AW-1:0] m0_req_addr;
  logic [DW-1:0] m0_req_wdata;
  logic [3:0]    m0_req_wstrb;
  logic          m0_rsp_valid, m0_rsp_err;
  logic [DW-1:0] m0_rsp_rdata;
  logic          m1_req_valid, m1_req_ready, m1_req_we;
  logic [AW-1:0] m1_req_addr;
  logic [DW-1:0] m1_req_wdata;
  logic [3:0]    m1_req_wstrb;
  logic          m1_rsp_valid, m1_rsp_err;
  logic [DW-1:0] m1_rsp_rdata;
  logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_cmd_wdata;
  logic [3:0]    mem_cmd_wstrb;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk50mhz(clk50mhz), .sys_rst_n(sys_rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata), .mem_cmd_wstrb(mem_cmd_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
  );

  always #10 clk50mhz = ~clk50mhz;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // requester-side pending requests
  bit          pv[2];
  bit          pwe[2];
  logic [AW-1:0] paddr[2];
  logic [DW-1:0] pwdata[2];
  logic [3:0]  pwstrb[2];

  // transaction-timing model
  bit          free = 1'b1;
  bit          last_win = 1'b1;
  bit          own;
  int          t_hs, a_cyc, rsp_cyc, rwait, late_cyc = -100;
  bit          txn_we;
  logic [AW-1:0] txn_addr;
  logic [DW-1:0] txn_wdata, rd_val, exp_rdata;
  logic [3:0]  txn_wstrb;
  bit          exp_err;

  // knobs
  int          f_dcmd = -1, f_r = -1, p_req = 0;
  bit          noise = 1'b0, f_data_en = 1'b0;
  logic [DW-1:0] f_data = '0;
  int          dut_grants[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int m, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] s);
    pv[m] = 1'b1; pwe[m] = we; paddr[m] = a; pwdata[m] = d; pwstrb[m] = s;
  endtask

  task automatic drive_reqs();
    m0_req_valid = pv[0]; m0_req_we = pwe[0]; m0_req_addr = paddr[0];
    m0_req_wdata = pwdata[0]; m0_req_wstrb = pwstrb[0];
    m1_req_valid = pv[1]; m1_req_we = pwe[1]; m1_req_addr = paddr[1];
    m1_req_wdata = pwdata[1]; m1_req_wstrb = pwstrb[1];
  endtask

  task automatic step();
    bit g, hs, in_issue, in_wait;
    bit er[2];
    bit rv[2];
    @(negedge clk50mhz);
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (!pv[m] && ($urandom_range(99) < p_req))
        set_req(m, 1'($urandom_range(1)), AW'($urandom), $urandom, 4'($urandom_range(15)));
    end
    drive_reqs();
    g = 1'b0; hs = 1'b0; er[0] = 1'b0; er[1] = 1'b0;
    if (free && (pv[0] || pv[1])) begin
      g = (pv[0] && pv[1]) ? !last_win : !pv[0];
      hs = 1'b1;
      er[g] = 1'b1;
    end
    in_issue = !free && cyc >= t_hs + 1 && cyc <= a_cyc;
    in_wait  = !free && !txn_we && cyc > a_cyc && cyc < rsp_cyc;
    mem_cmd_ready = in_issue ? (cyc == a_cyc) : (noise && ($urandom_range(1) == 1));
    if (in_wait) mem_rsp_valid = (cyc == a_cyc + 1 + rwait);
    else mem_rsp_valid = (cyc == late_cyc) || (noise && ($urandom_range(3) == 0));
    mem_rsp_rdata = (in_wait && cyc == a_cyc + 1 + rwait) ? rd_val : $urandom;
    #1;
    chk("m0_req_ready", m0_req_ready, er[0]);
    chk("m1_req_ready", m1_req_ready, er[1]);
    chk("busy", busy, !free);
    chk("mem_cmd_valid", mem_cmd_valid, in_issue);
    if (in_issue) begin
      chk("cmd_we", mem_cmd_we, txn_we);
      chk("cmd_addr", mem_cmd_addr, txn_addr);
      chk("cmd_wdata", mem_cmd_wdata, txn_wdata);
      chk("cmd_wstrb", mem_cmd_wstrb, txn_wstrb);
    end
    rv[0] = !free && cyc == rsp_cyc && !own;
    rv[1] = !free && cyc == rsp_cyc && own;
    chk("m0_rsp_valid", m0_rsp_valid, rv[0]);
    chk("m1_rsp_valid", m1_rsp_valid, rv[1]);
    if (rv[0]) begin
      chk("m0_rsp_rdata", m0_rsp_rdata, exp_rdata);
      chk("m0_rsp_err", m0_rsp_err, exp_err);
      chk("m1_quiet", {m1_rsp_rdata, m1_rsp_err}, 0);
    end
    if (rv[1]) begin
      chk("m1_rsp_rdata", m1_rsp_rdata, exp_rdata);
      chk("m1_rsp_err", m1_rsp_err, exp_err);
      chk("m0_quiet", {m0_rsp_rdata, m0_rsp_err}, 0);
    end
    if (m0_req_ready) dut_grants.push_back(0);
    if (m1_req_ready) dut_grants.push_back(1);
    // advance the model to the next cycle
    if (hs) begin
      own = g; last_win = g; free = 1'b0; t_hs = cyc;
      txn_we = pwe[g]; txn_addr = paddr[g]; txn_wdata = pwdata[g]; txn_wstrb = pwstrb[g];
      pv[g] = 1'b0;
      a_cyc = t_hs + 1 + ((f_dcmd >= 0) ? f_dcmd : $urandom_range(3));
      rwait = (f_r >= 0) ? f_r : $urandom_range(TO + 1);
      rd_val = f_data_en ? f_data : $urandom;
      late_cyc = txn_we ? -100 : a_cyc + 1 + rwait;
      if (txn_we) begin
        rsp_cyc = a_cyc + 1; exp_rdata = '0; exp_err = 1'b0;
      end else if (rwait <= TO - 1) begin
        rsp_cyc = a_cyc + 2 + rwait; exp_rdata = rd_val; exp_err = 1'b0;
      end else begin
        rsp_cyc = a_cyc + 1 + TO; exp_rdata = '0; exp_err = 1'b1;
      end
    end else if (!free && cyc == rsp_cyc) begin
      free = 1'b1;
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((!free || pv[0] || pv[1]) && n < bound) begin
      step();
      n++;
    end
    chk("drain_done", (free && !pv[0] && !pv[1]), 1);
  endtask

  task automatic do_reset();
    @(negedge clk50mhz);
    sys_rst_n = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    drive_reqs();
    mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    #1;
    chk("rst_ready", {m0_req_ready, m1_req_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", {mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata, mem_cmd_wstrb}, 0);
    chk("rst_rsp0", {m0_rsp_valid, m0_rsp_err, m0_rsp_rdata}, 0);
    chk("rst_rsp1", {m1_rsp_valid, m1_rsp_err, m1_rsp_rdata}, 0);
    free = 1'b1; last_win = 1'b1; late_cyc = -100;
    repeat (2) @(negedge clk50mhz);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      pwe[m] = 1'b0; paddr[m] = '0; pwdata[m] = '0; pwstrb[m] = 4'h0;
    end
    drive_reqs();
    mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    do_reset();

    // single zero-wait read from m0
    f_dcmd = 0; f_r = 0; f_data_en = 1'b1; f_data = 32'h1234_5678;
    set_req(0, 1'b0, 28'h000_0100, 32'h0, 4'h0);
    drain(50);
    f_data_en = 1'b0;

    // continuous conflict from reset: m0, m1, m0
    do_reset();
    dut_grants.delete();
    p_req = 100; f_r = -1; f_dcmd = -1;
    for (int n = 0; n < 200 && dut_grants.size() < 3; n++) step();
    p_req = 0;
    drain(100);
    chk("grant_count_ge3", (dut_grants.size() >= 3), 1);
    if (dut_grants.size() >= 3) begin
      chk("grant0", dut_grants[0], 0);
      chk("grant1", dut_grants[1], 1);
      chk("grant2", dut_grants[2], 0);
    end

    // write with 5 cycles of command back-pressure
    f_dcmd = 5;
    set_req(1, 1'b1, 28'h0ABC_DE0, 32'hCAFE_F00D, 4'hF);
    drain(50);

    // read timeout followed by a late reply
    f_dcmd = 0; f_r = TO + 1;
    set_req(0, 1'b0, 28'h000_0200, 32'h0, 4'h0);
    drain(50);
    repeat (4) step();

    // response arriving in the last counted cycle
    f_r = TO - 1;
    set_req(1, 1'b0, 28'h000_0300, 32'h0, 4'h0);
    drain(50);

    // reset while waiting for read data
    f_r = TO + 1;
    set_req(1, 1'b0, 28'h000_0400, 32'h0, 4'h0);
    repeat (4) step();
    chk("in_wait_before_rst", busy, 1);
    do_reset();
    dut_grants.delete();
    f_r = -1; f_dcmd = -1;
    set_req(0, 1'b1, 28'h000_0500, 32'h1111_2222, 4'h3);
    set_req(1, 1'b1, 28'h000_0600, 32'h3333_4444, 4'hC);
    drain(100);
    chk("post_rst_first_grant", (dut_grants.size() > 0) ? dut_grants[0] : 9, 0);

    // random traffic with noise on ignored inputs
    noise = 1'b1; p_req = 40;
    repeat (600) step();
    noise = 1'b0; p_req = 0;
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
